// File: rtl/ptp_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ptp_bridge_pkg
// Purpose : Shared types for the PTP bridge lookup path. Holds the TCAM result
//           and segment-info records, the merge skid-buffer state encoding and
//           the hit/miss result selection helper.
// Rev     : 1.0  initial release
// ============================================================================
package ptp_bridge_pkg;

  typedef struct packed {
    logic [3:0] action;
    logic [3:0] queue_id;
  } TCAM_RESULT_S;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [5:0] seg_len;
  } SEGMENT_INFO_S;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } LKUP_MERGE_STATE_E;

  // A miss carries no usable TCAM data, so the configured default stands in.
  function automatic TCAM_RESULT_S merge_result(input logic         found,
                                                input TCAM_RESULT_S hit,
                                                input TCAM_RESULT_S dflt);
    return found ? hit : dflt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lkup_rsp_merge_if.sv
`default_nettype none
// ============================================================================
// Module  : lkup_rsp_merge_if
// Purpose : Egress AXI-Stream bundle of the lookup response merger.
// Ports   : o_tvalid/o_tready handshake; o_tuser_* merged sideband.
//           master = merger side, slave = downstream consumer.
// Rev     : 1.0  initial release
// ============================================================================
interface lkup_rsp_merge_if
  import ptp_bridge_pkg::*;
#(
  parameter int USERMETADATA_WIDTH = 1
) ();

  logic                          o_tvalid;
  logic                          o_tready;
  TCAM_RESULT_S                  o_tuser_result;
  logic                          o_tuser_found;
  logic [USERMETADATA_WIDTH-1:0] o_tuser_usermetadata;
  SEGMENT_INFO_S                 o_tuser_segment_info;

  modport master (
    output o_tvalid, o_tuser_result, o_tuser_found,
           o_tuser_usermetadata, o_tuser_segment_info,
    input  o_tready
  );

  modport slave (
    input  o_tvalid, o_tuser_result, o_tuser_found,
           o_tuser_usermetadata, o_tuser_segment_info,
    output o_tready
  );

endinterface
`default_nettype wire

// File: rtl/lkup_rsp_skid2.sv
`default_nettype none
// ============================================================================
// Module  : lkup_rsp_skid2
// Purpose : Two-entry output skid buffer. Entry 0 (head) drives the output,
//           entry 1 (tail) absorbs one extra push while the head is stalled.
// Ports   : push/push_data in; ready in; valid/data out; pop out (handshake
//           taken this cycle); state out (occupancy, used for space look-ahead).
// Rev     : 1.0  initial release
// ============================================================================
module lkup_rsp_skid2
  import ptp_bridge_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              ready,
  output logic              valid,
  output logic              pop,
  output logic [WIDTH-1:0]  data,
  output LKUP_MERGE_STATE_E state
);

  LKUP_MERGE_STATE_E state_q, state_d;
  logic [WIDTH-1:0]  head_q, head_d;
  logic [WIDTH-1:0]  tail_q, tail_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Payload storage is intentionally unreset; it is don't-care while empty.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  // Next-state and payload movement. A push in TWO cannot happen because the
  // merger withholds buffer space, so it is simply ignored there.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          tail_d  = push_data;
          state_d = TWO;
        end else if (push && pop) begin
          head_d  = push_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    valid = (state_q != EMPTY);
    pop   = valid & ready;
    data  = head_q;
    state = state_q;
  end

endmodule
`default_nettype wire

// File: rtl/lkup_rsp_merge.sv
`default_nettype none
// ============================================================================
// Module  : lkup_rsp_merge
// Purpose : Joins each TCAM response with its per-packet metadata, substitutes
//           the default result on a miss, and presents the merged record on an
//           AXI-Stream egress through a 2-entry skid buffer. A watchdog flags
//           responses that sit without matching metadata.
// Ports   : clk, rst_n (async, active-low)
//           rsp_fifo_*/tcam_rsp_* : show-ahead TCAM response FIFO
//           meta_fifo_*/meta_*    : show-ahead metadata FIFO
//           cfg_default_result    : result used on a miss
//           o_axis                : egress stream (lkup_rsp_merge_if.master)
//           err_orphan_rsp        : sticky orphan-response error
//           stat_hit_cnt/stat_miss_cnt : only with LKUP_RSP_MERGE_STATS_EN
// Config  : `define LKUP_RSP_MERGE_STATS_EN adds saturating hit/miss counters.
// Rev     : 1.0  initial release
// ============================================================================
module lkup_rsp_merge
  import ptp_bridge_pkg::*;
#(
  parameter int USERMETADATA_WIDTH = 1,
  parameter int WDOG_WIDTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rsp_fifo_empty,
  input  TCAM_RESULT_S                  tcam_rsp_result,
  input  logic                          tcam_rsp_found,
  output logic                          rsp_fifo_rd,
  input  logic                          meta_fifo_empty,
  input  logic [USERMETADATA_WIDTH-1:0] meta_usermetadata,
  input  SEGMENT_INFO_S                 meta_segment_info,
  output logic                          meta_fifo_rd,
  input  TCAM_RESULT_S                  cfg_default_result,
  lkup_rsp_merge_if.master              o_axis,
  output logic                          err_orphan_rsp
`ifdef LKUP_RSP_MERGE_STATS_EN
  ,
  output logic [31:0]                   stat_hit_cnt,
  output logic [31:0]                   stat_miss_cnt
`endif
);

  localparam int PAYLOAD_W = $bits(TCAM_RESULT_S) + 1 + USERMETADATA_WIDTH
                           + $bits(SEGMENT_INFO_S);
  localparam logic [WDOG_WIDTH-1:0] WDOG_MAX = '1;

  logic                  space_q, space_d;
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic                  err_q, err_d;
  logic                  join_en;
  logic                  skid_pop;
  LKUP_MERGE_STATE_E     skid_state;
  logic [PAYLOAD_W-1:0]  payload;
  logic [PAYLOAD_W-1:0]  skid_data;

  // space_q resets low, so the earliest join is the second cycle after reset.
  assign join_en      = !rsp_fifo_empty & !meta_fifo_empty & space_q;
  assign rsp_fifo_rd  = join_en;
  assign meta_fifo_rd = join_en;

  assign payload = {merge_result(tcam_rsp_found, tcam_rsp_result, cfg_default_result),
                    tcam_rsp_found, meta_usermetadata, meta_segment_info};

  always_comb begin
    // Registered look-ahead: deny space next cycle whenever the buffer is, or
    // is about to become, full. Leaving TWO costs one bubble, never an overflow.
    space_d = (skid_state != TWO) & !((skid_state == ONE) & join_en & !skid_pop);

    if (!rsp_fifo_empty && meta_fifo_empty)
      wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
    else
      wdog_d = '0;

    err_d = err_q | (wdog_d == WDOG_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      space_q <= 1'b0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      space_q <= space_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign err_orphan_rsp = err_q;

  lkup_rsp_skid2 #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (join_en),
    .push_data (payload),
    .ready     (o_axis.o_tready),
    .valid     (o_axis.o_tvalid),
    .pop       (skid_pop),
    .data      (skid_data),
    .state     (skid_state)
  );

  assign {o_axis.o_tuser_result, o_axis.o_tuser_found,
          o_axis.o_tuser_usermetadata, o_axis.o_tuser_segment_info} = skid_data;

`ifdef LKUP_RSP_MERGE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (join_en && tcam_rsp_found && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (join_en && !tcam_rsp_found && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign stat_hit_cnt  = hit_cnt_q;
  assign stat_miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lkup_rsp_merge.sv
`default_nettype none
// ============================================================================
// Module  : tb_lkup_rsp_merge
// Purpose : Self-checking bench for lkup_rsp_merge. Models both show-ahead
//           FIFOs with queues and checks egress records against a scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lkup_rsp_merge;
  import ptp_bridge_pkg::*;

  localparam int UMW = 4;

  typedef struct packed {
    TCAM_RESULT_S   result;
    logic           found;
    logic [UMW-1:0] umeta;
    SEGMENT_INFO_S  seg;
  } out_t;

  typedef struct { TCAM_RESULT_S result; logic found; } rsp_t;
  typedef struct { logic [UMW-1:0] umeta; SEGMENT_INFO_S seg; } meta_t;

  typedef struct {
    logic           found;
    logic [7:0]     result;
    logic [7:0]     dflt;
    logic [UMW-1:0] umeta;
    logic [7:0]     seg;
    logic [7:0]     exp_result;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rsp_fifo_empty, meta_fifo_empty;
  TCAM_RESULT_S   tcam_rsp_result, cfg_default_result;
  logic           tcam_rsp_found;
  logic [UMW-1:0] meta_usermetadata;
  SEGMENT_INFO_S  meta_segment_info;
  logic           rsp_fifo_rd, meta_fifo_rd, err_orphan_rsp;
`ifdef LKUP_RSP_MERGE_STATS_EN
  logic [31:0]    stat_hit_cnt, stat_miss_cnt;
`endif

  lkup_rsp_merge_if #(.USERMETADATA_WIDTH(UMW)) axis ();

  lkup_rsp_merge #(.USERMETADATA_WIDTH(UMW), .WDOG_WIDTH(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rsp_fifo_empty     (rsp_fifo_empty),
    .tcam_rsp_result    (tcam_rsp_result),
    .tcam_rsp_found     (tcam_rsp_found),
    .rsp_fifo_rd        (rsp_fifo_rd),
    .meta_fifo_empty    (meta_fifo_empty),
    .meta_usermetadata  (meta_usermetadata),
    .meta_segment_info  (meta_segment_info),
    .meta_fifo_rd       (meta_fifo_rd),
    .cfg_default_result (cfg_default_result),
    .o_axis             (axis),
    .err_orphan_rsp     (err_orphan_rsp)
`ifdef LKUP_RSP_MERGE_STATS_EN
    ,
    .stat_hit_cnt       (stat_hit_cnt),
    .stat_miss_cnt      (stat_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  rsp_t  rq[$];
  meta_t mq[$];
  out_t  sb[$];
  int    total = 0, bad = 0;
  int    cyc = 0, join_cyc = 0, out_cyc = 0, n_join = 0, n_out = 0;
  int    exp_hit = 0, exp_miss = 0;
  logic  rand_mode = 1'b0, rsp_hide = 1'b0, meta_hide = 1'b0;
  logic  stall_prev = 1'b0;
  out_t  prev_data, last_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    rsp_fifo_empty    = (rq.size() == 0) | rsp_hide;
    meta_fifo_empty   = (mq.size() == 0) | meta_hide;
    tcam_rsp_result   = (rq.size() != 0) ? rq[0].result : '0;
    tcam_rsp_found    = (rq.size() != 0) ? rq[0].found  : 1'b0;
    meta_usermetadata = (mq.size() != 0) ? mq[0].umeta  : '0;
    meta_segment_info = (mq.size() != 0) ? mq[0].seg    : '0;
  endtask

  // Expected record is formed here, at stimulus time, from the bench's own
  // hit/miss rule and the default result in force.
  task automatic enqueue(input logic found, input logic [7:0] res,
                         input logic [UMW-1:0] um, input logic [7:0] seg);
    rsp_t r; meta_t m; out_t o;
    r.found = found; r.result = res;
    m.umeta = um;    m.seg    = seg;
    o.result = found ? TCAM_RESULT_S'(res) : cfg_default_result;
    o.found  = found; o.umeta = um; o.seg = seg;
    rq.push_back(r); mq.push_back(m); sb.push_back(o);
    refresh();
  endtask

  // One clock: observe at the falling edge, update FIFO models after the rise.
  task automatic step();
    logic rd_r, rd_m;
    out_t cur, exp;
    @(negedge clk);
    cyc++;
    rd_r = rsp_fifo_rd;
    rd_m = meta_fifo_rd;
    if (rd_r | rd_m)
      check("rd_legal", {rd_r, rd_m, rsp_fifo_empty, meta_fifo_empty}, 4'b1100);
    cur = {axis.o_tuser_result, axis.o_tuser_found,
           axis.o_tuser_usermetadata, axis.o_tuser_segment_info};
    if (stall_prev) begin
      check("stall_valid", axis.o_tvalid, 1);
      check("stall_data", cur, prev_data);
    end
    if (axis.o_tvalid && axis.o_tready) begin
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else begin
        exp = sb.pop_front();
        check("out_data", cur, exp);
      end
      n_out++; out_cyc = cyc; last_out = cur;
    end
    stall_prev = axis.o_tvalid & !axis.o_tready;
    prev_data  = cur;
    if (rd_r && rq.size() != 0) begin
      n_join++; join_cyc = cyc;
      if (rq[0].found) exp_hit++; else exp_miss++;
    end
    @(posedge clk);
    #1;
    if (rd_r && rq.size() != 0) void'(rq.pop_front());
    if (rd_m && mq.size() != 0) void'(mq.pop_front());
    if (rand_mode) begin
      rsp_hide      = ($urandom_range(0, 3) == 0);
      meta_hide     = ($urandom_range(0, 3) == 0);
      axis.o_tready = ($urandom_range(0, 3) != 0);
    end
    refresh();
  endtask

  task automatic drain(input string name, input int want, input int budget);
    int start = n_out;
    for (int i = 0; i < budget && (n_out - start) < want; i++) step();
    check(name, n_out - start, want);
  endtask

  task automatic check_stats();
`ifdef LKUP_RSP_MERGE_STATS_EN
    check("stat_hit", stat_hit_cnt, exp_hit);
    check("stat_miss", stat_miss_cnt, exp_miss);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    int j0, o0, sent;
    vecs[0] = '{1'b1, 8'h15, 8'h03, 4'h1, 8'h81, 8'h15};
    vecs[1] = '{1'b0, 8'h15, 8'h03, 4'h1, 8'h42, 8'h03};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 4'hF, 8'hC0, 8'hFF};
    vecs[3] = '{1'b0, 8'hAA, 8'h5C, 4'hA, 8'h3F, 8'h5C};
    vecs[4] = '{1'b1, 8'h00, 8'hFF, 4'h0, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 8'h77, 8'h00, 4'h6, 8'h55, 8'h00};

    axis.o_tready = 1'b1;
    cfg_default_result = 8'h03;
    refresh();

    // Reset state, with a pair already waiting in the FIFOs.
    repeat (3) @(posedge clk);
    #1;
    enqueue(1'b1, 8'h15, 4'h1, 8'h81);
    check("rst_tvalid", axis.o_tvalid, 0);
    check("rst_rd", {rsp_fifo_rd, meta_fifo_rd}, 0);
    check("rst_err", err_orphan_rsp, 0);
    check_stats();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("no_join_cycle1", n_join, 0);
    step();
    check("join_cycle2", n_join, 1);
    drain("hit_out", 1, 10);
    check("hit_latency", out_cyc - join_cyc, 1);
    check("hit_result", last_out.result, 8'h15);
    check("hit_found", last_out.found, 1);
    check("hit_meta", last_out.umeta, 1);
    check_stats();

    // Table-driven single pairs on an idle output.
    for (int i = 0; i < 6; i++) begin
      cfg_default_result = vecs[i].dflt;
      enqueue(vecs[i].found, vecs[i].result, vecs[i].umeta, vecs[i].seg);
      drain("vec_out", 1, 10);
      check("vec_latency", out_cyc - join_cyc, 1);
      check("vec_result", last_out.result, vecs[i].exp_result);
      check("vec_found", last_out.found, vecs[i].found);
    end
    check_stats();

    // Backpressure: only two joins fit while stalled.
    cfg_default_result = 8'h3C;
    axis.o_tready = 1'b0;
    j0 = n_join;
    for (int i = 0; i < 5; i++) enqueue(i[0], 8'h10 + 8'(i), 4'(i), 8'(i * 3));
    repeat (20) step();
    check("bp_joins", n_join - j0, 2);
    check("bp_tvalid", axis.o_tvalid, 1);
    axis.o_tready = 1'b1;
    drain("bp_out", 5, 60);
    check("bp_sb_empty", sb.size(), 0);
    check_stats();

    // Orphan response: watchdog saturates at 255.
    begin
      rsp_t r;
      r.found = 1'b1; r.result = 8'h99;
      rq.push_back(r);
      refresh();
    end
    j0 = n_join;
    repeat (254) step();
    check("orphan_err_254", err_orphan_rsp, 0);
    step();
    check("orphan_err_255", err_orphan_rsp, 1);
    check("orphan_no_rd", n_join - j0, 0);
    begin
      meta_t m; out_t o;
      m.umeta = 4'h9; m.seg = 8'h99;
      o.result = 8'h99; o.found = 1'b1; o.umeta = 4'h9; o.seg = 8'h99;
      mq.push_back(m); sb.push_back(o);
      refresh();
    end
    drain("orphan_out", 1, 10);
    repeat (3) step();
    check("orphan_err_sticky", err_orphan_rsp, 1);

    // Reset while the skid buffer holds two entries.
    axis.o_tready = 1'b0;
    j0 = n_join;
    for (int i = 0; i < 4; i++) enqueue(~i[0], 8'h60 + 8'(i), 4'(i + 8), 8'h70 + 8'(i));
    repeat (10) step();
    check("rs_joins", n_join - j0, 2);
    rst_n = 1'b0;
    #1;
    check("rs_tvalid", axis.o_tvalid, 0);
    check("rs_err", err_orphan_rsp, 0);
    exp_hit = 0; exp_miss = 0;
    check_stats();
    void'(sb.pop_front());
    void'(sb.pop_front());
    stall_prev = 1'b0;
    step();
    rst_n = 1'b1;
    axis.o_tready = 1'b1;
    drain("rs_out", 2, 20);
    check("rs_sb_empty", sb.size(), 0);
    check_stats();

    // Random soak.
    rand_mode = 1'b1;
    o0 = n_out;
    sent = 0;
    for (int c = 0; c < 80000 && (sent < 10000 || sb.size() != 0); c++) begin
      if (rq.size() < 3 && sent < 10000) begin
        enqueue(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), 8'($urandom));
        sent++;
      end
      step();
    end
    rand_mode = 1'b0; rsp_hide = 1'b0; meta_hide = 1'b0;
    refresh();
    check("soak_count", n_out - o0, 10000);
    check("soak_sb_empty", sb.size(), 0);
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lkup_rsp_merge.md
LKUP_RSP_MERGE -- requirements
Module: lkup_rsp_merge

Interface
REQ-001 Parameter USERMETADATA_WIDTH, default 1: width of per-packet user metadata carried alongside the lookup.
REQ-002 Parameter WDOG_WIDTH, default 8: width of the orphan-response watchdog counter.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 rsp_fifo_empty  in  1  TCAM response FIFO empty; show-ahead, so data is valid whenever this is low.
REQ-006 tcam_rsp_result  in  ptp_bridge_pkg::TCAM_RESULT_S  head TCAM result.
REQ-007 tcam_rsp_found  in  1  head entry hit flag.
REQ-008 rsp_fifo_rd  out  1  pops the response FIFO.
REQ-009 meta_fifo_empty  in  1  per-packet metadata FIFO empty; show-ahead.
REQ-010 meta_usermetadata  in  USERMETADATA_WIDTH  head metadata.
REQ-011 meta_segment_info  in  ptp_bridge_pkg::SEGMENT_INFO_S  head segment info.
REQ-012 meta_fifo_rd  out  1  pops the metadata FIFO.
REQ-013 cfg_default_result  in  ptp_bridge_pkg::TCAM_RESULT_S  result applied on a miss; quasi-static.
REQ-014 o_tvalid / o_tready  out / in  1 / 1  egress AXI-S handshake.
REQ-015 o_tuser_result  out  TCAM_RESULT_S; o_tuser_found  out  1; o_tuser_usermetadata  out  USERMETADATA_WIDTH; o_tuser_segment_info  out  SEGMENT_INFO_S.
REQ-016 err_orphan_rsp  out  1  sticky error: response present with no matching metadata.

Function
REQ-017 Pairing condition: join = !rsp_fifo_empty & !meta_fifo_empty & buffer space available.
REQ-018 When join is high, rsp_fifo_rd and meta_fifo_rd shall both be asserted in the same cycle. Neither read shall ever be asserted alone.
REQ-019 Merged result: o_tuser_result = tcam_rsp_found ? tcam_rsp_result : cfg_default_result, sampled at the join cycle.
REQ-020 Found, metadata and segment info pass through unchanged from the join cycle.
REQ-021 Latency: a join in cycle N presents o_tvalid in cycle N+1 when the output is idle.
REQ-022 Output is a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-023 Skid buffer transitions:
- EMPTY: join -> ONE.
- ONE: join without pop -> TWO; pop without join -> EMPTY; join with pop -> ONE.
- TWO: pop -> ONE; joins are blocked.
REQ-024 Pop = o_tvalid & o_tready.
REQ-025 Buffer space is registered: space = (state != TWO) & !(state == ONE & join & !pop) from the previous cycle's view. Joins shall never overflow the buffer, with o_tready held low indefinitely.
REQ-026 o_tvalid shall not drop, and o_tuser_* shall stay stable, while o_tvalid & !o_tready.
REQ-027 Ordering: outputs leave in join order (FIFO order).
REQ-028 Watchdog: count increments each cycle that !rsp_fifo_empty & meta_fifo_empty, clears otherwise, and saturates at all-ones.
REQ-029 Reaching all-ones sets err_orphan_rsp, which holds until reset.
REQ-030 Simultaneous join and pop in state TWO is impossible by construction, because join is blocked in TWO.

Reset
REQ-031 On rst_n low, asynchronously:
- state = EMPTY, o_tvalid = 0;
- rsp_fifo_rd = 0, meta_fifo_rd = 0;
- watchdog = 0, err_orphan_rsp = 0;
- counters = 0.
REQ-032 o_tuser_* data registers are not reset and are don't-care while o_tvalid = 0.
REQ-033 Reset mid-transfer discards buffered entries. Packets in the FIFOs are untouched and are processed after reset release.
REQ-034 First join is permitted in the second cycle after rst_n deasserts.

Configuration
REQ-035 Macro LKUP_RSP_MERGE_STATS_EN defined: add outputs stat_hit_cnt and stat_miss_cnt (32-bit each, saturating, zero at reset). Each increments once per join according to tcam_rsp_found.
REQ-036 Macro LKUP_RSP_MERGE_STATS_EN undefined: no counters and no stat ports; all other behaviour is identical.

Structure
REQ-037 TCAM_RESULT_S, SEGMENT_INFO_S and a new LKUP_MERGE_STATE_E enum (EMPTY, ONE, TWO) shall live in ptp_bridge_pkg.
REQ-038 One sub-module, lkup_rsp_skid2, shall implement the 2-entry skid buffer, parameterised on payload width. The join logic, watchdog and counters stay in the top module.

Verification
REQ-039 Hit pass-through: one response with found=1 and result=0x15 plus metadata 1, o_tready=1 -> single-cycle reads, o_tvalid one cycle later, result 0x15, found 1, metadata 1.
REQ-040 Miss substitution: found=0 with cfg_default_result=0x3 -> o_tuser_result=0x3, o_tuser_found=0; stat_miss_cnt=1 when the stats macro is defined.
REQ-041 Backpressure: 5 pairs queued with o_tready=0 -> exactly 2 joins. After o_tready=1, all 5 emerge in order with no loss and with stable data during stalls.
REQ-042 Orphan response: response FIFO non-empty, metadata FIFO empty for 255 cycles -> err_orphan_rsp=1 at cycle 255 with no reads. It stays set after metadata arrives and the pair drains.
REQ-043 Reset mid-stall: state TWO, rst_n low for 1 cycle -> o_tvalid=0 immediately, err and counters 0. Remaining FIFO pairs emerge after release.
REQ-044 Random soak: random empty and o_tready patterns for 10k packets -> scoreboard order and result match, with no read ever asserted while its FIFO is empty.
